namesuite_replay_issuer: RTL and testbench
==========================================

# namesuite_replay_issuer

Initiator side of the valid/replay handshake that the CompBlock family answers. It accepts one request at a time from an upstream producer and drives `io_valid`/`io_bits` toward a responder. If the responder asserts `io_replay` in the same cycle, the block backs off and re-issues the request. It gives up after a bounded number of replays and reports completion or failure to the producer.

## Interface

Parameters:
- `W`, 8: request payload width.
- `MAX_RETRY`, 3: replays tolerated before failure, legal range 0..15.
- `BACKOFF`, 2: idle cycles between a replay and the re-issue, legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_in_valid`  in  1  upstream request present.
- `io_in_ready`  out  1  block can accept a request.
- `io_in_bits`  in  W  request payload.
- `io_valid`  out  1  request issued to the responder.
- `io_bits`  out  W  issued payload.
- `io_replay`  in  1  responder rejects the current issue; sampled only while `io_valid`=1.
- `io_done`  out  1  one-cycle pulse: request accepted by the responder.
- `io_fail`  out  1  one-cycle pulse: request dropped after `MAX_RETRY` replays.
- `io_attempts`  out  4  replays seen by the most recently finished request.
- `io_replay_count`  out  16  total replays since reset, saturating at 0xFFFF.

## Operation

State machine with three states: IDLE, ISSUE, BACKOFF.

- **IDLE**
  - `io_in_ready`=1.
  - On `io_in_valid`: capture `io_in_bits` into the payload register, clear the retry counter, go to ISSUE.
- **ISSUE**
  - `io_valid`=1; `io_bits` = payload register.
  - If `io_replay`=0: pulse `io_done`, load `io_attempts` from the retry counter, go to IDLE.
  - If `io_replay`=1 and retry counter = `MAX_RETRY`: pulse `io_fail`, load `io_attempts` = `MAX_RETRY`, go to IDLE.
  - If `io_replay`=1 otherwise: increment the retry counter, load the backoff counter with `BACKOFF`-1, go to BACKOFF.
- **BACKOFF**
  - `io_valid`=0.
  - Decrement the backoff counter; go to ISSUE when it is 0.
- Every `io_replay`=1 sampled in ISSUE increments `io_replay_count`, including the one that causes a failure; the count holds at 0xFFFF.
- `io_replay` is ignored in IDLE and BACKOFF.
- `io_bits` holds the captured payload constant for the whole life of a request, including across backoff.

## Timing

- Reset values:
  - State: IDLE.
  - `io_in_ready`=1; `io_valid`=0; `io_bits`=0.
  - `io_done`=0; `io_fail`=0.
  - `io_attempts`=0; `io_replay_count`=0.
  - Payload, retry and backoff counters: 0.
- Output timing:
  - `io_in_ready` and `io_valid` decode combinationally from state.
  - `io_done`, `io_fail`, `io_attempts` and `io_replay_count` are registered.
- Latencies:
  - Request accepted in cycle t: `io_valid`=1 in cycle t+1.
  - Clean issue in cycle t: `io_done`=1 in t+1, where the block is also back in IDLE with `io_in_ready`=1.
  - A new request accepted in the `io_done` cycle issues at t+2; this gives back-to-back throughput of one request per 2 cycles.
- Replay in cycle t: `io_valid`=0 for t+1..t+`BACKOFF`, and the re-issue happens in t+`BACKOFF`+1.
- Worst-case life of a request: 1 + (`MAX_RETRY`+1) issues + `MAX_RETRY`·`BACKOFF` backoff cycles.
- `MAX_RETRY`=0: the first replay fails immediately and BACKOFF is never entered.
- `io_done` and `io_fail` are mutually exclusive and never assert on consecutive cycles for the same request.
- Reset asserted mid-request:
  - All state clears immediately and asynchronously.
  - `io_valid` drops in the same cycle.
  - The request is lost; no `io_done` or `io_fail` pulse is produced.

## Test plan

- **Reset:** assert `reset`=0 mid-BACKOFF → `io_valid`=0 at once; after release `io_in_ready`=1, `io_replay_count`=0, and no pulses appear.
- **Clean issue:** `io_in_bits`=0xA5 accepted at cycle 0, `io_replay` tied 0 → `io_valid`=1 with `io_bits`=0xA5 at cycle 1; `io_done`=1 at cycle 2; `io_attempts`=0.
- **Single replay, defaults:** accept at 0, `io_replay`=1 at cycle 1 only → `io_valid`=0 at cycles 2–3, re-issue at 4, `io_done` at 5; `io_attempts`=1; `io_replay_count`=1.
- **Exhaustion, defaults:** `io_replay` held 1 → issues at cycles 1, 4, 7, 10; `io_fail`=1 at cycle 11; `io_attempts`=3; `io_replay_count`=4; no `io_done`.
- **Back-to-back:** `io_in_valid` held 1 with payloads 0x01, 0x02, 0x03 and `io_replay`=0 → issues at cycles 1, 3, 5; `io_done` at 2, 4, 6; each `io_bits` matches its payload.
- **Stray replay and saturation:** `io_replay`=1 while IDLE or BACKOFF → no counter change; with the counter forced to 0xFFFF, a further replay → the count stays 0xFFFF.

Source files
------------

// File: rtl/namesuite_replay_issuer.sv
// Purpose: initiator side of a valid/replay handshake; issues one request, backs off and re-issues on replay.
// Latency: accept at t -> issue at t+1 -> done at t+2; each replay adds BACKOFF idle cycles before the re-issue.
// Backpressure: io_in_ready is high only in IDLE; io_replay from the responder pushes the request into backoff.
module namesuite_replay_issuer #(
    parameter int W         = 8,
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           io_in_valid,
    output logic           io_in_ready,
    input  logic [W-1:0]   io_in_bits,
    output logic           io_valid,
    output logic [W-1:0]   io_bits,
    input  logic           io_replay,
    output logic           io_done,
    output logic           io_fail,
    output logic [3:0]     io_attempts,
    output logic [15:0]    io_replay_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BACKOFF = 2'd2
    } state_t;

    localparam logic [3:0] MAX_R    = 4'(MAX_RETRY);
    localparam logic [3:0] BOFF_RLD = 4'(BACKOFF - 1);

    state_t         state;
    logic [W-1:0]   payload;
    logic [3:0]     retry_cnt;
    logic [3:0]     boff_cnt;
    logic [15:0]    replay_cnt;

    // Handshake strobes decode straight from state so they track the FSM with no lag.
    assign io_in_ready     = (state == ST_IDLE);
    assign io_valid        = (state == ST_ISSUE);
    assign io_bits         = payload;
    assign io_replay_count = replay_cnt;

    // Request FSM: capture, issue, back off on replay, give up after MAX_RETRY replays.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            payload     <= '0;
            retry_cnt   <= '0;
            boff_cnt    <= '0;
            replay_cnt  <= '0;
            io_done     <= 1'b0;
            io_fail     <= 1'b0;
            io_attempts <= '0;
        end else begin
            // Completion strobes are single-cycle pulses.
            io_done <= 1'b0;
            io_fail <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (io_in_valid) begin
                        payload   <= io_in_bits;
                        retry_cnt <= '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!io_replay) begin
                        io_done     <= 1'b1;
                        io_attempts <= retry_cnt;
                        state       <= ST_IDLE;
                    end else begin
                        // Every replay seen while issuing is counted, including the fatal one.
                        if (replay_cnt != 16'hFFFF) begin
                            replay_cnt <= replay_cnt + 16'd1;
                        end
                        if (retry_cnt == MAX_R) begin
                            io_fail     <= 1'b1;
                            io_attempts <= MAX_R;
                            state       <= ST_IDLE;
                        end else begin
                            retry_cnt <= retry_cnt + 4'd1;
                            boff_cnt  <= BOFF_RLD;
                            state     <= ST_BACKOFF;
                        end
                    end
                end
                ST_BACKOFF: begin
                    // Loading BACKOFF-1 and leaving at zero gives exactly BACKOFF idle cycles.
                    if (boff_cnt == 4'd0) begin
                        state <= ST_ISSUE;
                    end else begin
                        boff_cnt <= boff_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_namesuite_replay_issuer.sv
module tb_namesuite_replay_issuer;

    logic        clk;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [7:0]  io_in_bits;
    logic        io_valid;
    logic [7:0]  io_bits;
    logic        io_replay;
    logic        io_done;
    logic        io_fail;
    logic [3:0]  io_attempts;
    logic [15:0] io_replay_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    namesuite_replay_issuer #(.W(8), .MAX_RETRY(3), .BACKOFF(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .io_in_valid     (io_in_valid),
        .io_in_ready     (io_in_ready),
        .io_in_bits      (io_in_bits),
        .io_valid        (io_valid),
        .io_bits         (io_bits),
        .io_replay       (io_replay),
        .io_done         (io_done),
        .io_fail         (io_fail),
        .io_attempts     (io_attempts),
        .io_replay_count (io_replay_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check outputs at the negedge, drive inputs, advance to the next negedge.
    task automatic cyc(input string tag, input logic iv, input logic [7:0] ib, input logic rp,
                       input logic e_rdy, input logic e_vld, input logic e_done, input logic e_fail);
        chk({tag, ".rdy"},  {31'd0, io_in_ready}, {31'd0, e_rdy});
        chk({tag, ".vld"},  {31'd0, io_valid},    {31'd0, e_vld});
        chk({tag, ".done"}, {31'd0, io_done},     {31'd0, e_done});
        chk({tag, ".fail"}, {31'd0, io_fail},     {31'd0, e_fail});
        if (e_vld) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                chk({tag, ".bits"}, {24'd0, io_bits}, {24'd0, exp_q[0]});
                if (!rp) void'(exp_q.pop_front());
            end
        end
        if (e_fail && exp_q.size() != 0) void'(exp_q.pop_front());
        if (e_rdy && iv) exp_q.push_back(ib);
        io_in_valid = iv;
        io_in_bits  = ib;
        io_replay   = rp;
        @(negedge clk);
    endtask

    initial begin
        io_in_valid = 1'b0;
        io_in_bits  = 8'h00;
        io_replay   = 1'b0;
        reset       = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Reset values
        chk("rst.rdy",   {31'd0, io_in_ready}, 32'd1);
        chk("rst.vld",   {31'd0, io_valid},    32'd0);
        chk("rst.bits",  {24'd0, io_bits},     32'd0);
        chk("rst.att",   {28'd0, io_attempts}, 32'd0);
        chk("rst.count", {16'd0, io_replay_count}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Clean issue
        cyc("clean.c0", 1, 8'hA5, 0, 1, 0, 0, 0);
        cyc("clean.c1", 0, 8'h00, 0, 0, 1, 0, 0);
        chk("clean.att", {28'd0, io_attempts}, 32'd0);
        cyc("clean.c2", 0, 8'h00, 0, 1, 0, 1, 0);

        // Single replay, with stray replays during backoff that must be ignored
        cyc("one.c0", 1, 8'h5A, 0, 1, 0, 0, 0);
        cyc("one.c1", 0, 8'h00, 1, 0, 1, 0, 0);
        cyc("one.c2", 0, 8'h00, 1, 0, 0, 0, 0);
        cyc("one.c3", 0, 8'h00, 1, 0, 0, 0, 0);
        cyc("one.c4", 0, 8'h00, 0, 0, 1, 0, 0);
        chk("one.att",   {28'd0, io_attempts}, 32'd1);
        chk("one.count", {16'd0, io_replay_count}, 32'd1);
        cyc("one.c5", 0, 8'h00, 0, 1, 0, 1, 0);

        // Stray replay while idle
        cyc("idle.c0", 0, 8'h00, 1, 1, 0, 0, 0);
        cyc("idle.c1", 0, 8'h00, 1, 1, 0, 0, 0);
        cyc("idle.c2", 0, 8'h00, 0, 1, 0, 0, 0);
        chk("idle.count", {16'd0, io_replay_count}, 32'd1);

        // Back-to-back requests with in_valid held
        cyc("b2b.c0", 1, 8'h01, 0, 1, 0, 0, 0);
        cyc("b2b.c1", 1, 8'h02, 0, 0, 1, 0, 0);
        cyc("b2b.c2", 1, 8'h02, 0, 1, 0, 1, 0);
        cyc("b2b.c3", 1, 8'h03, 0, 0, 1, 0, 0);
        cyc("b2b.c4", 1, 8'h03, 0, 1, 0, 1, 0);
        cyc("b2b.c5", 0, 8'h00, 0, 0, 1, 0, 0);
        cyc("b2b.c6", 0, 8'h00, 0, 1, 0, 1, 0);

        // Exhaustion: replay held high
        cyc("exh.c0", 1, 8'hC3, 1, 1, 0, 0, 0);
        for (int c = 1; c <= 10; c++) begin
            cyc($sformatf("exh.c%0d", c), 0, 8'h00, 1, 0, (c % 3) == 1, 0, 0);
        end
        chk("exh.att",   {28'd0, io_attempts}, 32'd3);
        chk("exh.count", {16'd0, io_replay_count}, 32'd5);
        cyc("exh.c11", 0, 8'h00, 0, 1, 0, 0, 1);
        cyc("exh.c12", 0, 8'h00, 0, 1, 0, 0, 0);
        chk("exh.sb_drained", exp_q.size(), 32'd0);

        // Reset mid-BACKOFF
        cyc("rb.c0", 1, 8'h77, 0, 1, 0, 0, 0);
        cyc("rb.c1", 0, 8'h00, 1, 0, 1, 0, 0);
        reset = 1'b0;
        #1;
        chk("rb.vld",   {31'd0, io_valid},    32'd0);
        chk("rb.rdy",   {31'd0, io_in_ready}, 32'd1);
        chk("rb.count", {16'd0, io_replay_count}, 32'd0);
        chk("rb.bits",  {24'd0, io_bits},     32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc($sformatf("rb.post%0d", c), 0, 8'h00, 0, 1, 0, 0, 0);
        end

        // Reset while issuing drops io_valid at once and produces no pulse
        cyc("ri.c0", 1, 8'h3C, 0, 1, 0, 0, 0);
        chk("ri.vld_pre", {31'd0, io_valid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("ri.vld", {31'd0, io_valid}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        cyc("ri.post0", 0, 8'h00, 0, 1, 0, 0, 0);
        cyc("ri.post1", 0, 8'h00, 0, 1, 0, 0, 0);

        // Saturation of the replay counter
        force dut.replay_cnt = 16'hFFFF;
        #1;
        release dut.replay_cnt;
        chk("sat.pre", {16'd0, io_replay_count}, 32'h0000FFFF);
        cyc("sat.c0", 1, 8'hE1, 0, 1, 0, 0, 0);
        cyc("sat.c1", 0, 8'h00, 1, 0, 1, 0, 0);
        chk("sat.hold", {16'd0, io_replay_count}, 32'h0000FFFF);
        cyc("sat.c2", 0, 8'h00, 0, 0, 0, 0, 0);
        cyc("sat.c3", 0, 8'h00, 0, 0, 0, 0, 0);
        cyc("sat.c4", 0, 8'h00, 0, 0, 1, 0, 0);
        chk("sat.att", {28'd0, io_attempts}, 32'd1);
        cyc("sat.c5", 0, 8'h00, 0, 1, 0, 1, 0);
        chk("sat.final", {16'd0, io_replay_count}, 32'h0000FFFF);
        chk("sat.sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
